// File: rtl/ifid_pkg.sv
// Shared definitions for the IF/ID pipeline buffer: instruction width, NOP encoding.
package ifid_pkg;
    localparam int INSTR_W = 16;
    typedef logic [INSTR_W-1:0] instr_t;
    localparam instr_t NOP_INSTR = 16'h0000;
endpackage

// File: rtl/buffer_ifid_pipe_reg.sv
// Generic WIDTH-bit register: sync reset value, sync clear-to-constant, hold enable.
module pipe_reg #(
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clr,
    input  logic             hold,
    input  logic             clk,
    input  logic             rst
);
    // Priority: reset, then clear, then hold, then load.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_VAL;
        else if (clr)
            q <= CLR_VAL;
        else if (!hold)
            q <= d;
    end
endmodule

// File: rtl/buffer_ifid.sv
// IF/ID pipeline buffer; flush squashes the captured fetch to NOP.
// Optional hazard-unit freeze via `stall` when BUFFER_IFID_STALL_EN is defined.
module buffer_ifid
    import ifid_pkg::*;
#(
    parameter int WIDTH = INSTR_W,
    parameter logic [WIDTH-1:0] NOP_VALUE = NOP_INSTR
) (
    output logic [WIDTH-1:0] out_instr,
    input  logic [WIDTH-1:0] in_instr,
    input  logic             flush,
    input  logic             clk,
    input  logic             rst
`ifdef BUFFER_IFID_STALL_EN
    ,
    input  logic             stall
`endif
);
    logic hold;

`ifdef BUFFER_IFID_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    pipe_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (NOP_VALUE),
        .CLR_VAL (NOP_VALUE)
    ) u_reg (
        .q    (out_instr),
        .d    (in_instr),
        .clr  (flush),
        .hold (hold),
        .clk  (clk),
        .rst  (rst)
    );
endmodule

// File: tb/tb_buffer_ifid.sv
// Directed bench for buffer_ifid; stall vectors run only with BUFFER_IFID_STALL_EN.
module tb_buffer_ifid;
    logic [15:0] out_instr;
    logic [15:0] in_instr;
    logic        flush;
    logic        clk;
    logic        rst;
`ifdef BUFFER_IFID_STALL_EN
    logic        stall;
`endif

    int total = 0;
    int bad   = 0;

    buffer_ifid dut (
        .out_instr (out_instr),
        .in_instr  (in_instr),
        .flush     (flush),
        .clk       (clk),
        .rst       (rst)
`ifdef BUFFER_IFID_STALL_EN
        ,
        .stall     (stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1ns later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_instr = 16'hF230;
`ifdef BUFFER_IFID_STALL_EN
        stall = 1'b0;
`endif
        tick; chk("rst0", out_instr, 16'h0000);
        tick; chk("rst1", out_instr, 16'h0000);

        rst = 1'b0;
        in_instr = 16'hF230; tick; chk("str0", out_instr, 16'hF230);
        in_instr = 16'hF400; tick; chk("str1", out_instr, 16'hF400);
        in_instr = 16'hF500; tick; chk("str2", out_instr, 16'hF500);

        in_instr = 16'hF600; flush = 1'b1; tick; chk("flush", out_instr, 16'h0000);
        in_instr = 16'hF700; flush = 1'b0; tick; chk("postflush", out_instr, 16'hF700);

        flush = 1'b1;
        in_instr = 16'h1234; tick; chk("flushn0", out_instr, 16'h0000);
        in_instr = 16'h5678; tick; chk("flushn1", out_instr, 16'h0000);
        flush = 1'b0;
        in_instr = 16'h9ABC; tick; chk("flushrel", out_instr, 16'h9ABC);

        // Flush pulse falling entirely between edges must be ignored.
        in_instr = 16'h0F0F;
        #2 flush = 1'b1;
        #2 flush = 1'b0;
        tick; chk("glitch", out_instr, 16'h0F0F);

        rst = 1'b1; in_instr = 16'hF400; tick; chk("rstmid", out_instr, 16'h0000);
        rst = 1'b1; flush = 1'b1; in_instr = 16'hBEEF; tick; chk("rstflush", out_instr, 16'h0000);
        rst = 1'b0; flush = 1'b0; in_instr = 16'hC0DE; tick; chk("rstrel", out_instr, 16'hC0DE);

`ifdef BUFFER_IFID_STALL_EN
        in_instr = 16'hF400; tick; chk("stpre", out_instr, 16'hF400);
        stall = 1'b1;
        in_instr = 16'h1111; tick; chk("stall0", out_instr, 16'hF400);
        in_instr = 16'h2222; tick; chk("stall1", out_instr, 16'hF400);
        in_instr = 16'h3333; tick; chk("stall2", out_instr, 16'hF400);
        flush = 1'b1; tick; chk("stflush", out_instr, 16'h0000);
        flush = 1'b0; stall = 1'b0;
        in_instr = 16'h4444; tick; chk("strel", out_instr, 16'h4444);
        stall = 1'b1; rst = 1'b1; tick; chk("strst", out_instr, 16'h0000);
        stall = 1'b0; rst = 1'b0;
`endif

        in_instr = 16'hFFFF; tick; chk("allones", out_instr, 16'hFFFF);
        in_instr = 16'h0001; tick; chk("lsb", out_instr, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
